// File: rtl/axis_frame_gen.sv
// Periodic AXI-Stream frame generator: a period counter raises ticks, each tick
// requests one Ethernet-style frame with a timestamped header beat followed by
// payload beats whose bytes carry the beat index.
module axis_frame_gen #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned KEEP_WIDTH = 32
) (
    input  logic                  rtc_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           period,
    input  logic [7:0]            frame_beats,
    input  logic [5:0]            last_bytes,
    input  logic                  is_critical,
    input  logic [47:0]           dst_mac,
    input  logic [47:0]           src_mac,
    input  logic [15:0]           it_ethertype,
    input  logic [15:0]           crit_ethertype,
    input  logic [63:0]           rtc_time,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [31:0]           frames_sent,
    output logic [15:0]           dropped_ticks,
    output logic                  busy
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    localparam logic [KEEP_WIDTH:0] KeepOne = {{KEEP_WIDTH{1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [15:0]           dropped_q, dropped_d;
    logic [31:0]           frames_q, frames_d;
    logic [7:0]            beat_q, beat_d;
    logic [7:0]            beats_q, beats_d;
    logic [KEEP_WIDTH-1:0] last_keep_q, last_keep_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;

    logic [31:0]           eff_period;
    logic                  tick;
    logic                  start;
    logic [7:0]            eff_beats;
    logic [5:0]            eff_last;
    logic [KEEP_WIDTH:0]   keep_wide;
    logic [KEEP_WIDTH-1:0] in_keep;
    logic [15:0]           ethertype;
    logic [DATA_WIDTH-1:0] hdr_be;
    logic [DATA_WIDTH-1:0] hdr;
    logic [7:0]            beat_next;
    logic                  next_is_last;

    assign eff_period = (period == 32'd0) ? 32'd1 : period;
    assign tick       = enable && (cnt_q == eff_period - 32'd1);
    assign start      = (state_q == StIdle) && pending_q;

    assign eff_beats  = (frame_beats == 8'd0) ? 8'd1 : frame_beats;
    assign eff_last   = (last_bytes == 6'd0 || last_bytes > 6'd32) ? 6'd32 : last_bytes;
    assign keep_wide  = (KeepOne << eff_last) - KeepOne;
    assign in_keep    = keep_wide[KEEP_WIDTH-1:0];
    assign ethertype  = is_critical ? crit_ethertype : it_ethertype;

    // Header built MSB-first, then byte-swapped so byte 0 lands in bits [7:0].
    assign hdr_be     = {dst_mac, src_mac, ethertype, frames_q, rtc_time, 48'h0};

    assign beat_next    = beat_q + 8'd1;
    assign next_is_last = (beat_next == beats_q - 8'd1);

    // Byte-reverse the big-endian header into AXIS byte order.
    always_comb begin
        hdr = '0;
        for (int k = 0; k < int'(KEEP_WIDTH); k++) begin
            hdr[8*k +: 8] = hdr_be[int'(DATA_WIDTH) - 1 - 8*k -: 8];
        end
    end

    // Period counter: free-runs 0..P-1 while enabled, parked at 0 otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = 32'd0;
        end else if (tick) begin
            cnt_d = 32'd0;
        end else begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Tick request flag and lost-tick counter; a tick coinciding with a start re-arms.
    always_comb begin
        pending_d = pending_q;
        dropped_d = dropped_q;
        if (tick) begin
            pending_d = 1'b1;
        end else if (start) begin
            pending_d = 1'b0;
        end
        if (tick && pending_q && !start && dropped_q != 16'hFFFF) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    // Frame FSM: latch the frame on start, then walk beats on each handshake.
    always_comb begin
        state_d     = state_q;
        frames_d    = frames_q;
        beat_d      = beat_q;
        beats_d     = beats_q;
        last_keep_d = last_keep_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        unique case (state_q)
            StIdle: begin
                if (pending_q) begin
                    state_d     = StSend;
                    beat_d      = 8'd0;
                    beats_d     = eff_beats;
                    last_keep_d = in_keep;
                    tdata_d     = hdr;
                    tlast_d     = (eff_beats == 8'd1);
                    tkeep_d     = (eff_beats == 8'd1) ? in_keep : '1;
                end
            end
            StSend: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        state_d  = StIdle;
                        frames_d = frames_q + 32'd1;
                        tlast_d  = 1'b0;
                    end else begin
                        beat_d  = beat_next;
                        tdata_d = {KEEP_WIDTH{beat_next}};
                        tlast_d = next_is_last;
                        tkeep_d = next_is_last ? last_keep_q : '1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge rtc_clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 32'd0;
            pending_q   <= 1'b0;
            dropped_q   <= 16'd0;
            frames_q    <= 32'd0;
            beat_q      <= 8'd0;
            beats_q     <= 8'd1;
            last_keep_q <= '1;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pending_q   <= pending_d;
            dropped_q   <= dropped_d;
            frames_q    <= frames_d;
            beat_q      <= beat_d;
            beats_q     <= beats_d;
            last_keep_q <= last_keep_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = (state_q == StSend);
    assign busy          = (state_q == StSend);
    assign frames_sent   = frames_q;
    assign dropped_ticks = dropped_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Scoreboard bench for axis_frame_gen: stimulus pushes expected beats, a negedge
// monitor pops and compares on every handshake and checks hold/gap behaviour.
module tb_axis_frame_gen;

    logic         rtc_clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [31:0]  period;
    logic [7:0]   frame_beats;
    logic [5:0]   last_bytes;
    logic         is_critical;
    logic [47:0]  dst_mac, src_mac;
    logic [15:0]  it_ethertype, crit_ethertype;
    logic [63:0]  rtc_time;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]  frames_sent;
    logic [15:0]  dropped_ticks;
    logic         busy;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    int    rise_q[$];
    int    vectors = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    frames_seen = 0;
    int    hs_count = 0;

    // Monitor state
    logic         prev_v = 1'b0;
    logic         prev_last_hs = 1'b0;
    logic         hold = 1'b0;
    logic [255:0] hd;
    logic [31:0]  hk;
    logic         hl;

    always #5 rtc_clk = ~rtc_clk;

    axis_frame_gen #(.DATA_WIDTH(256), .KEEP_WIDTH(32)) dut (
        .rtc_clk        (rtc_clk),
        .reset          (reset),
        .enable         (enable),
        .period         (period),
        .frame_beats    (frame_beats),
        .last_bytes     (last_bytes),
        .is_critical    (is_critical),
        .dst_mac        (dst_mac),
        .src_mac        (src_mac),
        .it_ethertype   (it_ethertype),
        .crit_ethertype (crit_ethertype),
        .rtc_time       (rtc_time),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .frames_sent    (frames_sent),
        .dropped_ticks  (dropped_ticks),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Header model: explicit byte placement, byte 0 in bits [7:0].
    function automatic logic [255:0] make_hdr(input logic [47:0] d, input logic [47:0] s,
                                              input logic [15:0] e, input logic [31:0] seq,
                                              input logic [63:0] ts);
        logic [7:0]   b [32];
        logic [255:0] r;
        for (int i = 0; i < 32; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]     = d[8*(5-i) +: 8];
            b[6 + i] = s[8*(5-i) +: 8];
        end
        b[12] = e[15:8];
        b[13] = e[7:0];
        for (int i = 0; i < 4; i++) b[14 + i] = seq[8*(3-i) +: 8];
        for (int i = 0; i < 8; i++) b[18 + i] = ts[8*(7-i) +: 8];
        for (int i = 0; i < 32; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    task automatic push_frame(input logic [255:0] hdr, input int nbeats, input int total,
                              input logic [31:0] last_keep);
        beat_t      bt;
        logic [7:0] bb;
        for (int b = 0; b < nbeats; b++) begin
            bb      = b[7:0];
            bt.data = (b == 0) ? hdr : {32{bb}};
            bt.last = (b == total - 1);
            bt.keep = bt.last ? last_keep : 32'hFFFF_FFFF;
            exp_q.push_back(bt);
        end
    endtask

    task automatic step();
        @(posedge rtc_clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!m_axis_tvalid && n < budget) begin
            step();
            n++;
        end
        check("wait_tvalid", {255'd0, m_axis_tvalid}, 256'd1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames_sent != target && n < budget) begin
            step();
            n++;
        end
        check("frames_sent", {224'd0, frames_sent}, target);
    endtask

    initial forever begin
        @(posedge rtc_clk);
        cyc++;
    end

    // Monitor: scoreboard pop on handshake, hold check under backpressure, idle gap check.
    initial forever begin
        beat_t e;
        @(negedge rtc_clk);
        if (prev_last_hs) check("gap_after_last", {255'd0, m_axis_tvalid}, 256'd0);
        prev_last_hs = 1'b0;
        if (m_axis_tvalid && !prev_v) rise_q.push_back(cyc);
        prev_v = m_axis_tvalid;
        if (m_axis_tvalid && m_axis_tready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_beat: got %h expected no beat", m_axis_tdata);
            end else begin
                e = exp_q.pop_front();
                check("beat_tdata", m_axis_tdata, e.data);
                check("beat_tkeep", {224'd0, m_axis_tkeep}, {224'd0, e.keep});
                check("beat_tlast", {255'd0, m_axis_tlast}, {255'd0, e.last});
            end
            if (m_axis_tlast) begin
                frames_seen++;
                prev_last_hs = 1'b1;
            end
            hold = 1'b0;
        end else if (m_axis_tvalid) begin
            if (hold) begin
                check("hold_tdata", m_axis_tdata, hd);
                check("hold_tkeep", {224'd0, m_axis_tkeep}, {224'd0, hk});
                check("hold_tlast", {255'd0, m_axis_tlast}, {255'd0, hl});
            end
            hold = 1'b1;
            hd   = m_axis_tdata;
            hk   = m_axis_tkeep;
            hl   = m_axis_tlast;
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, base, fs0, hs0, nf;
        logic [63:0] ts1;
        reset          = 1'b1;
        enable         = 1'b0;
        period         = 32'd100;
        frame_beats    = 8'd2;
        last_bytes     = 6'd10;
        is_critical    = 1'b0;
        dst_mac        = 48'h0102_0304_0506;
        src_mac        = 48'h0A0B_0C0D_0E0F;
        it_ethertype   = 16'h0806;
        crit_ethertype = 16'h88F7;
        ts1            = 64'h1122_3344_5566_7788;
        rtc_time       = ts1;
        m_axis_tready  = 1'b1;
        repeat (3) step();

        check("rst_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        check("rst_tlast", {255'd0, m_axis_tlast}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_tkeep", {224'd0, m_axis_tkeep}, 256'd0);
        check("rst_tdata", m_axis_tdata, 256'd0);
        check("rst_frames", {224'd0, frames_sent}, 256'd0);
        check("rst_dropped", {240'd0, dropped_ticks}, 256'd0);
        reset = 1'b0;
        step();

        // Basic frame, repeated every 100 cycles.
        push_frame(256'h000000000000_8877665544332211_00000000_0608_0F0E0D0C0B0A_060504030201,
                   2, 2, 32'h0000_03FF);
        push_frame(make_hdr(dst_mac, src_mac, 16'h0806, 32'd1, ts1), 2, 2, 32'h0000_03FF);
        rise_q.delete();
        c0     = cyc;
        enable = 1'b1;
        wait_frames(2, 400);
        enable = 1'b0;
        check("tick_to_tvalid", 256'(rise_q[0] - c0), 256'd101);
        check("frame_interval", 256'(rise_q[1] - rise_q[0]), 256'd100);
        check("no_drops", {240'd0, dropped_ticks}, 256'd0);

        // Critical single-beat frame.
        step();
        period      = 32'd50;
        is_critical = 1'b1;
        frame_beats = 8'd1;
        last_bytes  = 6'd0;
        push_frame(make_hdr(dst_mac, src_mac, 16'h88F7, 32'd2, ts1), 1, 1, 32'hFFFF_FFFF);
        enable = 1'b1;
        wait_frames(3, 200);
        enable = 1'b0;

        // Backpressure on beat 1 of 3.
        step();
        is_critical = 1'b0;
        frame_beats = 8'd3;
        last_bytes  = 6'd5;
        push_frame(make_hdr(dst_mac, src_mac, 16'h0806, 32'd3, ts1), 3, 3, 32'h0000_001F);
        hs0    = hs_count;
        enable = 1'b1;
        wait_valid(200);
        step();
        m_axis_tready = 1'b0;
        repeat (5) step();
        check("busy_in_frame", {255'd0, busy}, 256'd1);
        m_axis_tready = 1'b1;
        wait_frames(4, 50);
        enable = 1'b0;
        check("bp_handshakes", 256'(hs_count - hs0), 256'd3);

        // Inputs changed mid-frame must not affect the frame in flight.
        step();
        frame_beats = 8'd2;
        last_bytes  = 6'd32;
        rtc_time    = 64'hCAFE_0000_1234_5678;
        push_frame(make_hdr(dst_mac, src_mac, 16'h0806, 32'd4, 64'hCAFE_0000_1234_5678),
                   2, 2, 32'hFFFF_FFFF);
        enable = 1'b1;
        wait_valid(200);
        rtc_time     = 64'hDEAD_BEEF_0000_0001;
        dst_mac      = 48'hFFFF_FFFF_FFFF;
        src_mac      = 48'h1111_2222_3333;
        is_critical  = 1'b1;
        frame_beats  = 8'd5;
        last_bytes   = 6'd3;
        it_ethertype = 16'h1234;
        wait_frames(5, 50);
        enable = 1'b0;

        // Reset during beat 1 of 4.
        step();
        dst_mac      = 48'h0102_0304_0506;
        src_mac      = 48'h0A0B_0C0D_0E0F;
        is_critical  = 1'b0;
        it_ethertype = 16'h0806;
        rtc_time     = ts1;
        frame_beats  = 8'd4;
        last_bytes   = 6'd32;
        push_frame(make_hdr(dst_mac, src_mac, 16'h0806, 32'd5, ts1), 2, 4, 32'hFFFF_FFFF);
        enable = 1'b1;
        wait_valid(200);
        step();
        reset  = 1'b1;
        enable = 1'b0;
        step();
        check("rst_mid_tvalid", {255'd0, m_axis_tvalid}, 256'd0);
        check("rst_mid_frames", {224'd0, frames_sent}, 256'd0);
        check("rst_mid_busy", {255'd0, busy}, 256'd0);
        reset       = 1'b0;
        frame_beats = 8'd1;
        last_bytes  = 6'd10;
        push_frame(make_hdr(dst_mac, src_mac, 16'h0806, 32'd0, ts1), 1, 1, 32'h0000_03FF);
        step();
        enable = 1'b1;
        wait_frames(1, 200);
        enable = 1'b0;

        // Overrun: ticks every 2 cycles, 8-beat frames.
        step();
        period      = 32'd2;
        frame_beats = 8'd8;
        last_bytes  = 6'd32;
        base        = int'(frames_sent);
        fs0         = frames_seen;
        for (int f = 0; f < 12; f++) begin
            push_frame(make_hdr(dst_mac, src_mac, 16'h0806, 32'(base + f), ts1), 8, 8,
                       32'hFFFF_FFFF);
        end
        enable = 1'b1;
        wait_frames(base + 10, 150);
        enable = 1'b0;
        repeat (30) step();
        nf = frames_seen - fs0;
        check("dropped_nonzero", {255'd0, (dropped_ticks != 16'd0)}, 256'd1);
        check("frames_vs_seen", 256'(int'(frames_sent) - base), 256'(nf));
        check("leftover_beats", 256'(exp_q.size()), 256'(8 * (12 - nf)));
        check("idle_after", {255'd0, busy}, 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
